bit_serial_adder: RTL and testbench



---
 rtl/bit_serial_adder.sv | 125 ++++++++++++
 tb/tb_bit_serial_adder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder cell and a registered carry add two WIDTH-bit
// operands one bit per clock, LSB first, behind a start/busy/done handshake.

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (.x(x),  .y(y),  .s(s0), .c(c0));
    half_adder u_ha1 (.x(s0), .y(ci), .s(s),  .c(c1));

    assign co = c0 | c1;
endmodule

module bit_serial_adder #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        RUN  = 3'b010,
        DONE = 3'b100
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] ss;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             s_bit;
    logic             co_bit;

    full_adder u_fa (
        .x  (sa[0]),
        .y  (sb[0]),
        .ci (c),
        .s  (s_bit),
        .co (co_bit)
    );

    // On the last bit, c still holds the carry into the MSB, so overflow is
    // taken straight from it rather than from a separate capture register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            ss    <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        c     <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    ss  <= {s_bit, ss[WIDTH-1:1]};
                    c   <= co_bit;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum   <= {s_bit, ss[WIDTH-1:1]};
                        cout  <= co_bit;
                        ovf   <= co_bit ^ c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder: an 8-bit and a 64-bit instance,
// results predicted into per-instance queues and compared when done pulses.

module tb_bit_serial_adder;
    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        start8, cin8, busy8, done8, cout8, ovf8;
    logic [7:0]  a8, b8, sum8;
    logic        start64, cin64, busy64, done64, cout64, ovf64;
    logic [63:0] a64, b64, sum64;

    bit_serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    bit_serial_adder #(.WIDTH(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .start(start64), .a(a64), .b(b64), .cin(cin64),
        .busy(busy64), .done(done64), .sum(sum64), .cout(cout64), .ovf(ovf64)
    );

    exp_t        q8[$];
    exp_t        q64[$];
    int          applied = 0;
    int          miscompares = 0;
    int          done_count8 = 0;
    logic [63:0] last_sum8 = '0;
    logic [63:0] last_sum64 = '0;
    bit          use64 = 1'b0;
    vec_t        vecs[10];

    logic        cur_busy, cur_done;
    logic [63:0] cur_sum;
    assign cur_busy = use64 ? busy64 : busy8;
    assign cur_done = use64 ? done64 : done8;
    assign cur_sum  = use64 ? sum64 : {56'd0, sum8};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input bit wide);
        exp_t e;
        logic [64:0] full;
        logic [8:0]  narrow;
        if (wide) begin
            full   = {1'b0, a} + {1'b0, b} + {64'd0, cin};
            e.sum  = full[63:0];
            e.cout = full[64];
            e.ovf  = (a[63] == b[63]) && (e.sum[63] != a[63]);
        end else begin
            narrow = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'd0, cin};
            e.sum  = {56'd0, narrow[7:0]};
            e.cout = narrow[8];
            e.ovf  = (a[7] == b[7]) && (narrow[7] != a[7]);
        end
        return e;
    endfunction

    // Result checker: every done pulse must match the oldest outstanding prediction.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done8) begin
            done_count8++;
            if (q8.size() == 0) begin
                check("unexpected_done8", 1'b1, 1'b0);
            end else begin
                e = q8.pop_front();
                check("sum8",  {56'd0, sum8}, e.sum);
                check("cout8", cout8, e.cout);
                check("ovf8",  ovf8,  e.ovf);
            end
        end
        if (rst_n && done64) begin
            if (q64.size() == 0) begin
                check("unexpected_done64", 1'b1, 1'b0);
            end else begin
                e = q64.pop_front();
                check("sum64",  sum64,  e.sum);
                check("cout64", cout64, e.cout);
                check("ovf64",  ovf64,  e.ovf);
            end
        end
        if (busy8 && done8) check("busy_done_overlap8", 1'b1, 1'b0);
        if (busy64 && done64) check("busy_done_overlap64", 1'b1, 1'b0);
    end

    task automatic run_op(input bit wide, input logic [63:0] a, input logic [63:0] b,
                          input logic cin, input exp_t e, input string name);
        int          w;
        int          cycles;
        int          busy_cnt;
        bit          seen;
        bit          held;
        logic [63:0] prev;
        w    = wide ? 64 : 8;
        prev = wide ? last_sum64 : last_sum8;
        @(negedge clk);
        use64 = wide;
        if (wide) begin
            a64 = a; b64 = b; cin64 = cin; start64 = 1'b1;
            q64.push_back(e);
        end else begin
            a8 = a[7:0]; b8 = b[7:0]; cin8 = cin; start8 = 1'b1;
            q8.push_back(e);
        end
        @(negedge clk);
        start8 = 1'b0;
        start64 = 1'b0;
        cycles = 1; busy_cnt = 0; seen = 1'b0; held = 1'b1;
        while (!seen && cycles <= w + 8) begin
            if (cur_done) begin
                seen = 1'b1;
            end else begin
                if (cur_busy) busy_cnt++;
                if (cur_sum !== prev) held = 1'b0;
                @(negedge clk);
                cycles++;
            end
        end
        check({name, "_done_seen"}, seen, 1'b1);
        check({name, "_latency"}, cycles, w + 1);
        check({name, "_busy_cycles"}, busy_cnt, w);
        check({name, "_sum_held"}, held, 1'b1);
        @(negedge clk);
        check({name, "_done_one_cycle"}, cur_done, 1'b0);
        if (wide) last_sum64 = e.sum;
        else      last_sum8  = e.sum;
    endtask

    task automatic wait_done8(input int limit, output int cycles);
        cycles = 1;
        while (!done8 && cycles <= limit) begin
            @(negedge clk);
            cycles++;
        end
        check("wait_done8_timeout", done8, 1'b1);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        exp_t e;
        int   cycles;
        int   dc0;
        bit   held;
        logic [7:0] ra, rb;
        logic [63:0] wa, wb;
        logic rc;

        vecs[0] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[1] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        vecs[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1};
        vecs[4] = '{8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[7] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[8] = '{8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0};
        vecs[9] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};

        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start64 = 1'b0; a64 = '0; b64 = '0; cin64 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy8", busy8, 1'b0);
        check("rst_done8", done8, 1'b0);
        check("rst_sum8", {56'd0, sum8}, 64'd0);
        check("rst_cout8", cout8, 1'b0);
        check("rst_ovf8", ovf8, 1'b0);
        check("rst_busy64", busy64, 1'b0);
        check("rst_done64", done64, 1'b0);
        check("rst_sum64", sum64, 64'd0);

        for (int i = 0; i < 10; i++) begin
            e.sum = {56'd0, vecs[i].sum}; e.cout = vecs[i].cout; e.ovf = vecs[i].ovf;
            run_op(1'b0, {56'd0, vecs[i].a}, {56'd0, vecs[i].b}, vecs[i].cin, e, "vec8");
        end

        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            run_op(1'b0, {56'd0, ra}, {56'd0, rb}, rc, model({56'd0, ra}, {56'd0, rb}, rc, 1'b0), "rand8");
        end

        e.sum = 64'd0; e.cout = 1'b1; e.ovf = 1'b0;
        run_op(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, e, "ripple64");
        for (int i = 0; i < 2; i++) begin
            wa = {$urandom, $urandom};
            wb = {$urandom, $urandom};
            rc = 1'($urandom_range(0, 1));
            run_op(1'b1, wa, wb, rc, model(wa, wb, rc, 1'b1), "rand64");
        end
        use64 = 1'b0;

        // Second start pulse mid-run with new operands must be ignored.
        dc0 = done_count8;
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        q8.push_back(model(64'h12, 64'h34, 1'b0, 1'b0));
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(20, cycles);
        repeat (12) @(negedge clk);
        check("ignore_start_done_count", done_count8 - dc0, 1);
        check("ignore_start_sum", {56'd0, sum8}, 64'h46);
        check("ignore_start_busy", busy8, 1'b0);

        // Asynchronous reset during RUN clears outputs before the next edge.
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy8, 1'b0);
        check("midrst_done", done8, 1'b0);
        check("midrst_sum", {56'd0, sum8}, 64'd0);
        check("midrst_cout", cout8, 1'b0);
        check("midrst_sum64", sum64, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_sum8 = '0;
        last_sum64 = '0;
        repeat (2) @(negedge clk);
        check("midrst_idle_done", done8, 1'b0);
        e.sum = 64'h07; e.cout = 1'b0; e.ovf = 1'b0;
        run_op(1'b0, 64'h03, 64'h04, 1'b0, e, "after_rst");

        // Back-to-back: restart in the DONE cycle, old result held until new done.
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        e.sum = 64'h02; e.cout = 1'b0; e.ovf = 1'b0;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(20, cycles);
        check("b2b_first_latency", cycles, 9);
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b1; start8 = 1'b1;
        e.sum = 64'h01; e.cout = 1'b1; e.ovf = 1'b1;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        check("b2b_busy_rise", busy8, 1'b1);
        check("b2b_done_low", done8, 1'b0);
        check("b2b_sum_prev", {56'd0, sum8}, 64'h02);
        held = 1'b1;
        cycles = 1;
        while (!done8 && cycles <= 20) begin
            if (sum8 !== 8'h02) held = 1'b0;
            @(negedge clk);
            cycles++;
        end
        check("b2b_done_seen", done8, 1'b1);
        check("b2b_latency", cycles, 9);
        check("b2b_sum_hold", held, 1'b1);
        repeat (3) @(negedge clk);

        check("q8_drained", q8.size(), 0);
        check("q64_drained", q64.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
